// File: rtl/rvee_bus_arb.sv
// rvee_bus_arb: shares one external memory bus between the fetch port and
// the data (mem) port. One transaction is in flight at a time. It passes
// through an address phase (ADDR) and then a response phase (RESP).
// Data requests normally win arbitration. A starvation counter lets fetch
// win after STARVE_LIMIT consecutive mem grants that fetch had to wait for.
// A fetch flush marks the in-flight fetch as killed. The killed fetch still
// completes on the bus, but its response is not delivered.
module rvee_bus_arb #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              f_req,
    input  logic [XLEN-1:0]   f_addr,
    input  logic              f_flush,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [XLEN-1:0]   f_rdata,
    output logic              f_err,
    // data port
    input  logic              m_req,
    input  logic              m_we,
    input  logic [XLEN-1:0]   m_addr,
    input  logic [XLEN-1:0]   m_wdata,
    input  logic [XLEN/8-1:0] m_be,
    output logic              m_gnt,
    output logic              m_rvalid,
    output logic [XLEN-1:0]   m_rdata,
    output logic              m_err,
    // external bus
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_be,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata,
    input  logic              bus_err,
    output logic              busy
);

    localparam int              BE_W      = XLEN / 8;
    localparam logic [CNT_W-1:0] LIMIT_C  = CNT_W'(STARVE_LIMIT);
    localparam logic            OWN_FETCH = 1'b0;
    localparam logic            OWN_MEM   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r, state_n_s;
    logic               owner_r, owner_n_s;
    logic               kill_r, kill_n_s;
    logic [CNT_W-1:0]   starve_cnt_r, starve_cnt_n_s;

    logic               bus_we_r;
    logic [XLEN-1:0]    bus_addr_r;
    logic [XLEN-1:0]    bus_wdata_r;
    logic [BE_W-1:0]    bus_be_r;

    logic               complete_s;
    logic               capture_ok_s;
    logic               fetch_win_s;
    logic               f_gnt_s;
    logic               m_gnt_s;
    logic               f_rvalid_s;
    logic               m_rvalid_s;

    // Saturating increment of the starvation counter, capped at the limit.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= LIMIT_C) begin
            return LIMIT_C;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Completion detection, arbitration and grant generation.
    always_comb begin
        complete_s = 1'b0;
        case (state_r)
            ADDR:    complete_s = bus_gnt & bus_rvalid;
            RESP:    complete_s = bus_rvalid;
            default: complete_s = 1'b0;
        endcase
        // Grants are held low while reset is asserted, even in IDLE.
        capture_ok_s = rst_n & ((state_r == IDLE) | complete_s);
        fetch_win_s  = f_req & (~m_req | (starve_cnt_r == LIMIT_C));
        f_gnt_s      = capture_ok_s & fetch_win_s;
        m_gnt_s      = capture_ok_s & m_req & ~fetch_win_s;
        // A flush in the completion cycle also suppresses the fetch response.
        f_rvalid_s   = complete_s & (owner_r == OWN_FETCH) & ~kill_r & ~f_flush;
        m_rvalid_s   = complete_s & (owner_r == OWN_MEM);
    end

    // Next-state, owner, kill and starvation counter computation.
    always_comb begin
        state_n_s      = state_r;
        owner_n_s      = owner_r;
        kill_n_s       = kill_r;
        starve_cnt_n_s = starve_cnt_r;

        if (f_gnt_s | m_gnt_s) begin
            state_n_s = ADDR;
        end else if (complete_s) begin
            state_n_s = IDLE;
        end else if ((state_r == ADDR) && bus_gnt) begin
            state_n_s = RESP;
        end else begin
            state_n_s = state_r;
        end

        if (f_gnt_s) begin
            owner_n_s = OWN_FETCH;
        end else if (m_gnt_s) begin
            owner_n_s = OWN_MEM;
        end else begin
            owner_n_s = owner_r;
        end

        if (f_gnt_s) begin
            kill_n_s = f_flush;
        end else if (complete_s) begin
            kill_n_s = 1'b0;
        end else if ((state_r != IDLE) && (owner_r == OWN_FETCH) && f_flush) begin
            kill_n_s = 1'b1;
        end else begin
            kill_n_s = kill_r;
        end

        if (f_gnt_s) begin
            starve_cnt_n_s = {CNT_W{1'b0}};
        end else if (m_gnt_s && f_req) begin
            starve_cnt_n_s = sat_inc(starve_cnt_r);
        end else begin
            starve_cnt_n_s = starve_cnt_r;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            owner_r      <= OWN_FETCH;
            kill_r       <= 1'b0;
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_n_s;
            owner_r      <= owner_n_s;
            kill_r       <= kill_n_s;
            starve_cnt_r <= starve_cnt_n_s;
        end
    end

    // Bus address-phase fields, latched from the winner on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_we_r    <= 1'b0;
            bus_addr_r  <= {XLEN{1'b0}};
            bus_wdata_r <= {XLEN{1'b0}};
            bus_be_r    <= {BE_W{1'b0}};
        end else if (f_gnt_s) begin
            bus_we_r    <= 1'b0;
            bus_addr_r  <= f_addr;
            bus_wdata_r <= {XLEN{1'b0}};
            bus_be_r    <= {BE_W{1'b1}};
        end else if (m_gnt_s) begin
            bus_we_r    <= m_we;
            bus_addr_r  <= m_addr;
            bus_wdata_r <= m_wdata;
            bus_be_r    <= m_be;
        end else begin
            bus_we_r    <= bus_we_r;
            bus_addr_r  <= bus_addr_r;
            bus_wdata_r <= bus_wdata_r;
            bus_be_r    <= bus_be_r;
        end
    end

    assign f_gnt     = f_gnt_s;
    assign m_gnt     = m_gnt_s;
    assign f_rvalid  = f_rvalid_s;
    assign m_rvalid  = m_rvalid_s;
    assign f_err     = f_rvalid_s & bus_err;
    assign m_err     = m_rvalid_s & bus_err;
    assign f_rdata   = bus_rdata;
    assign m_rdata   = bus_rdata;
    assign bus_req   = (state_r == ADDR);
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;
    assign bus_be    = bus_be_r;
    assign busy      = (state_r != IDLE);

endmodule
